fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end of the pipelined RV32 core, directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions with their PC and PC+4 in a small prefetch queue, and hands them to decode over a valid/ready handshake.
- Takes redirects (taken branch, jal, jalr) from the MEM-stage resolution logic, flushes the queue and drops any in-flight fetch.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- redirect_valid  in  1  taken control transfer this cycle.
- redirect_pc  in  32  redirect target; bits[1:0] are forced to 0 internally.
- id_ready  in  1  decode accepts the head entry this cycle; low = stall.
- imem_req  out  1  instruction-memory read strobe.
- imem_addr  out  32  word-aligned fetch address.
- imem_rdata  in  32  instruction, valid the cycle after imem_req.
- out_valid  out  1  head entry valid.
- out_inst  out  32  head instruction.
- out_pc  out  32  head PC.
- out_pc_add4  out  32  head PC+4.
- fill_count  out  clog2(DEPTH)+1  occupied queue entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; queue empty, pointers 0; in-flight flag 0.
  - Outputs: imem_req=0, out_valid=0, fill_count=0, out_inst/out_pc/out_pc_add4=0.
  - Reset mid-operation discards everything; the next fetch is at RESET_PC.
- Issue (combinational):
  - imem_req = redirect_valid OR (fill_count + inflight < DEPTH).
  - imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : fetch_pc.
  - A pop in the same cycle does not free a slot for issue; the credit check is conservative.
- fetch_pc update on a clock edge:
  - If imem_req issues: fetch_pc <= imem_addr + 4. Arithmetic is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
  - Otherwise fetch_pc holds.
- In-flight tracking:
  - inflight_q <= imem_req; req_pc_q <= imem_addr.
  - Next cycle, if inflight_q=1 and there was no redirect in that cycle, push {imem_rdata, req_pc_q, req_pc_q+4}.
- Output:
  - out_* are driven combinationally from the queue head; out_valid = (fill_count != 0) AND NOT redirect_valid.
  - Pop when out_valid AND id_ready.
  - Push and pop in the same cycle: fill_count unchanged, pointers wrap modulo DEPTH.
  - Push is never attempted when full; the credit rule guarantees this, and an assertion checks it.
- Redirect (redirect_valid=1 in cycle t):
  - Queue cleared at the edge ending t, and the cycle-t pop is suppressed.
  - A response arriving in t is discarded.
  - The fetch at redirect_pc issues in t; its entry is pushed at the end of t+1, so out_valid=1 with out_pc=redirect_pc in t+2.
  - Back-to-back redirects: the newest wins; each discards the previous in-flight fetch.
- Latency:
  - Reset release to first out_valid: 2 cycles.
  - Sustained throughput: 1 instruction/cycle while id_ready=1.
- Stall: with id_ready=0 the queue fills to DEPTH, then imem_req=0 until a pop occurs.

Decomposition:
- Shared package cpu_pkg:
  - XLEN=32 and INST_W=32.
  - RESET_PC default.
  - NOP encoding 32'h0000_0013, used by decode for bubbles.
  - Fetch-entry struct {inst, pc, pc_add4}.
- One sub-module: fetch_queue, a synchronous FIFO of fetch entries.
  - Ports: push, pop, flush, full, empty, count.
  - flush has priority over push and pop.

Test Plan:
- Reset held low, then released with id_ready=1 → imem_addr 0,4,8,… on consecutive cycles; out_valid first high 2 cycles after release with out_pc=0, out_pc_add4=4; one instruction per cycle thereafter.
- id_ready=0 from reset → fill_count reaches 4; imem_req=0 afterwards; raising id_ready pops PCs 0,4,8,12 in order with no duplicates.
- Queue full (PCs 0..12 buffered), then redirect_valid=1 with redirect_pc=32'h100 → out_valid=0 that cycle; fill_count=0 next; out_pc=32'h100 two cycles later; entries 0..12 are never presented.
- Redirect to 32'h200 while a fetch of 32'h40 is in flight → 32'h40 is never pushed; the next presented PC is 32'h200.
- redirect_pc=32'h103 → imem_addr=32'h100; out_pc=32'h100.
- Run past 2×DEPTH entries with random id_ready → pointer wrap preserves order; assert reset=0 mid-stream → outputs zero immediately, and the next fetch is RESET_PC.
- Fetch at 32'hFFFF_FFFC → the next imem_addr is 32'h0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the RV32 pipeline front end.
//   XLEN / INST_W     : datapath and instruction widths
//   RESET_PC_DEFAULT  : default first fetch address
//   NOP_INST          : addi x0,x0,0, inserted by decode as a bubble
//   fetchEntry_t      : one prefetch-queue entry {inst, pc, pcAdd4}
//   alignWord()       : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcAdd4;
    } fetchEntry_t;

    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles every fetch-unit signal except clock and reset.
//   Redirect : redirect_valid, redirect_pc         (MEM stage -> fetch)
//   Decode   : id_ready                            (decode -> fetch)
//              out_valid, out_inst, out_pc,
//              out_pc_add4, fill_count             (fetch -> decode)
//   I-memory : imem_req, imem_addr                 (fetch -> memory)
//              imem_rdata                          (memory -> fetch)
// modport master: the fetch unit side.  modport slave: its environment.
// -----------------------------------------------------------------------------
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
);

    logic                     redirect_valid;
    logic [XLEN-1:0]          redirect_pc;
    logic                     id_ready;
    logic                     imem_req;
    logic [XLEN-1:0]          imem_addr;
    logic [INST_W-1:0]        imem_rdata;
    logic                     out_valid;
    logic [INST_W-1:0]        out_inst;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_pc_add4;
    logic [$clog2(DEPTH):0]   fill_count;

    modport master (
        input  redirect_valid, redirect_pc, id_ready, imem_rdata,
        output imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_add4, fill_count
    );

    modport slave (
        output redirect_valid, redirect_pc, id_ready, imem_rdata,
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_add4, fill_count
    );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of fetch entries.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   flush        : empties the queue; wins over push and pop
//   push/pushData: write one entry at the tail
//   pop          : retire the head entry
//   headData     : head entry (meaningful only while !empty)
//   full, empty, count : occupancy
// -----------------------------------------------------------------------------
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetchEntry_t            pushData,
    output fetchEntry_t            headData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetchEntry_t      storage [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign doPop    = pop && !empty;
    // A pop in the same cycle makes room, so a push into a full queue is legal then.
    assign doPush   = push && (!full || doPop);
    assign headData = storage[rdPtr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // NOTE: the entry array has no reset; an entry is only observed after it
    // has been written, because occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (doPush && !flush) storage[wrPtr] <= pushData;
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end feeding the IF/ID register.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : fetch_unit_if.master (redirect in, decode handshake, i-memory port)
// Issues one word read per cycle while the queue has credit, pairs each
// response with its PC, and presents the queue head to decode.  A redirect
// flushes the queue, drops the in-flight response and fetches the target.
// -----------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetchPc;
    logic [XLEN-1:0]  reqPcQ;
    logic             inflightQ;
    logic             imemReq;
    logic [XLEN-1:0]  imemAddr;
    logic             credit;
    logic             push;
    logic             pop;
    logic             outValid;
    fetchEntry_t      pushEntry;
    fetchEntry_t      head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        credit   = 1'b0;
        imemReq  = 1'b0;
        imemAddr = fetchPc;
        // An issued read is counted against the queue until it is pushed, so a
        // response always has a slot; a same-cycle pop is deliberately ignored.
        credit = (count + CNT_W'(inflightQ)) < CNT_W'(DEPTH);
        if (bus.redirect_valid) imemAddr = alignWord(bus.redirect_pc);
        // Held off during reset so memory sees no strobe while the core is idle.
        imemReq = reset && (bus.redirect_valid || credit);
    end

    // The response that lands in a redirect cycle belongs to the old path.
    assign push      = inflightQ && !bus.redirect_valid;
    assign outValid  = !empty && !bus.redirect_valid;
    assign pop       = outValid && bus.id_ready;
    assign pushEntry = '{inst: bus.imem_rdata, pc: reqPcQ, pcAdd4: reqPcQ + 32'd4};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetchPc   <= RESET_PC;
            reqPcQ    <= '0;
            inflightQ <= 1'b0;
        end else begin
            inflightQ <= imemReq;
            reqPcQ    <= imemAddr;
            if (imemReq) fetchPc <= imemAddr + 32'd4;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) queue (
        .clock    (clock),
        .reset    (reset),
        .flush    (bus.redirect_valid),
        .push     (push),
        .pop      (pop),
        .pushData (pushEntry),
        .headData (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign bus.imem_req    = imemReq;
    assign bus.imem_addr   = imemAddr;
    assign bus.out_valid   = outValid;
    // Data is forced to zero while empty so stale or unwritten entries never show.
    assign bus.out_inst    = empty ? '0 : head.inst;
    assign bus.out_pc      = empty ? '0 : head.pc;
    assign bus.out_pc_add4 = empty ? '0 : head.pcAdd4;
    assign bus.fill_count  = count;

    pushWhenFull: assert property (@(posedge clock) disable iff (!reset) !(push && full));

endmodule
